load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports, clock and reset first, as listed below.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_ready  output  1  unit idle and accepting requests.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_size  input  2  00=byte, 01=half, 10=word, 11=reserved.
REQ-008 req_signed  input  1  sign-extend sub-word loads.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result, extended; 0 for stores/errors.
REQ-013 resp_err  output  1  misaligned or reserved access; valid with resp_valid.
REQ-014 mem_addr  output  32  word-aligned address to data memory (req_addr with bits[1:0]=0).
REQ-015 mem_w_data  output  32  write data to data memory.
REQ-016 mem_r_mem  output  1  read strobe; memory returns data at falling edge of same cycle.
REQ-017 mem_w_mem  output  1  write strobe; memory writes at next rising edge.
REQ-018 mem_r_data  input  32  read data from memory, stable by end of strobe cycle.

Function
REQ-019 States SHALL be IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-020 Request accepted when req_valid&&req_ready at a rising edge; all req_* captured then, later changes ignored.
REQ-021 req_valid while not IDLE SHALL be ignored, no queuing.
REQ-022 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 11: IDLE->RESP, no memory strobe, resp_err=1.
REQ-023 Load: IDLE->RD->RESP; mem_r_mem=1 for exactly the RD cycle; mem_r_data captured at end of RD.
REQ-024 Word store: IDLE->WR->RESP; mem_w_mem=1 for the WR cycle, mem_w_data=req_wdata.
REQ-025 Sub-word store: IDLE->RD->WR->RESP read-modify-write; only addressed lanes replaced, others kept from RD data.
REQ-026 Byte lanes little-endian: byte k = bits[8k+7:8k]; half at addr[1] selects bits[15:0] or [31:16].
REQ-027 Loads: selected lane right-justified, sign-extended if req_signed else zero-extended.
REQ-028 RESP lasts one cycle: resp_valid=1, then IDLE; next request acceptable in cycle after RESP.
REQ-029 Latency from acceptance edge to resp_valid: load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-030 mem_r_mem and mem_w_mem SHALL never be asserted in the same cycle.
REQ-031 mem_addr/mem_w_data held stable throughout each strobe cycle; 0 in IDLE.

Reset
REQ-032 With rst high at a rising edge: state=IDLE, all outputs 0 except req_ready=1, captured request cleared.
REQ-033 Reset mid-operation aborts: no resp_valid and no pending strobe issued; a RD-phase RMW leaves memory unmodified.
REQ-034 rst has priority over a simultaneous req_valid.

Configuration
REQ-035 Macro LSU_SUBWORD_EN defined: byte/half accesses per REQ-025..027.
REQ-036 LSU_SUBWORD_EN undefined: only size 10 legal; sizes 00/01/11 take the REQ-022 error path; no RMW logic or WR-after-RD transition.

Verification
REQ-037 Word store 0xDEADBEEF @0x10, then word load @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after each acceptance.
REQ-038 Memory word @0x20=0x11223344; byte store 0xAA @0x21 -> mem_w_data=0x1122AA44, resp 3 cycles after acceptance.
REQ-039 Word @0x20=0x8000FF80; signed byte load @0x20 -> 0xFFFFFF80; unsigned half load @0x22 -> 0x00008000.
REQ-040 Word load @0x13 -> resp_err=1, resp_rdata=0, one cycle after acceptance, no mem_r_mem/mem_w_mem.
REQ-041 Byte store accepted, rst high during RD cycle -> no mem_w_mem, no resp_valid, req_ready=1 after reset, memory word unchanged.
REQ-042 req_valid held high continuously with back-to-back word loads -> acceptances exactly 3 cycles apart, intermediate req_valid ignored.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle between a CPU-side requester, the load/store unit and a single-port data memory.
// The unit takes the slave modport. The requester and memory side take the master modport.
interface load_store_unit_if;
    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // req_ready is high only while the unit is idle, and the unit keeps no queue.
    // Every transfer is answered by exactly one single-cycle resp_valid pulse,
    // unless reset intervenes. resp_err and resp_rdata are meaningful only with resp_valid.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic        mem_r_mem;
    logic        mem_w_mem;
    logic [31:0] mem_r_data;
    logic [1:0]  state_dbg;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_r_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_w_data, mem_r_mem, mem_w_mem, state_dbg
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_r_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_w_data, mem_r_mem, mem_w_mem, state_dbg
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time, with alignment checks and lane extraction or merging.
// Define LSU_SUBWORD_EN to enable byte and half accesses, which use read-modify-write for sub-word stores.
module load_store_unit (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

    state_t      state;
    state_t      state_nx;
    logic        req_fire;
    logic        req_err;
    logic        cap_we;
    logic        cap_err;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] rd_data;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign req_fire = bus.req_valid && (state == IDLE);

`ifdef LSU_SUBWORD_EN
    logic [1:0]  cap_size;
    logic        cap_signed;
    logic [4:0]  shamt;
    logic [31:0] lane;
    logic [31:0] mask;

    always_comb begin
        req_err = 1'b1;
        case (bus.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = |bus.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_size   <= 2'b00;
            cap_signed <= 1'b0;
        end else if (req_fire) begin
            cap_size   <= bus.req_size;
            cap_signed <= bus.req_signed;
        end
    end

    // Loads shift the addressed lane down. Stores replace only that lane of the word read in RD.
    always_comb begin
        load_data  = rd_data;
        store_data = cap_wdata;
        shamt      = 5'd0;
        lane       = 32'd0;
        mask       = 32'd0;
        case (cap_size)
            2'b00: begin
                shamt      = {cap_addr[1:0], 3'b000};
                lane       = rd_data >> shamt;
                load_data  = cap_signed ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
                mask       = 32'h0000_00FF << shamt;
                store_data = (rd_data & ~mask) | ((cap_wdata & 32'h0000_00FF) << shamt);
            end
            2'b01: begin
                shamt      = {cap_addr[1], 4'b0000};
                lane       = rd_data >> shamt;
                load_data  = cap_signed ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
                mask       = 32'h0000_FFFF << shamt;
                store_data = (rd_data & ~mask) | ((cap_wdata & 32'h0000_FFFF) << shamt);
            end
            default: begin
                load_data  = rd_data;
                store_data = cap_wdata;
            end
        endcase
    end
`else
    logic unused_lsu_bits;

    assign req_err         = (bus.req_size != 2'b10) || (|bus.req_addr[1:0]);
    assign load_data       = rd_data;
    assign store_data      = cap_wdata;
    assign unused_lsu_bits = ^{bus.req_signed, cap_addr[1:0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            rd_data   <= 32'd0;
        end else begin
            if (req_fire) begin
                cap_we    <= bus.req_we;
                cap_err   <= req_err;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end
            if (state == RD) begin
                rd_data <= bus.mem_r_data;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_err) begin
                        state_nx = RESP;
                    end else if (!bus.req_we) begin
                        state_nx = RD;
`ifdef LSU_SUBWORD_EN
                    end else if (bus.req_size != 2'b10) begin
                        state_nx = RD;
`endif
                    end else begin
                        state_nx = WR;
                    end
                end
            end
`ifdef LSU_SUBWORD_EN
            RD:      state_nx = cap_we ? WR : RESP;
`else
            RD:      state_nx = RESP;
`endif
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The address and write data are driven only during strobe cycles and are zero otherwise.
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'd0;
        bus.mem_addr   = 32'd0;
        bus.mem_w_data = 32'd0;
        bus.mem_r_mem  = 1'b0;
        bus.mem_w_mem  = 1'b0;
        bus.state_dbg  = state;
        case (state)
            RD: begin
                bus.mem_r_mem = 1'b1;
                bus.mem_addr  = {cap_addr[31:2], 2'b00};
            end
            WR: begin
                bus.mem_w_mem  = 1'b1;
                bus.mem_addr   = {cap_addr[31:2], 2'b00};
                bus.mem_w_data = store_data;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = cap_err;
                bus.resp_rdata = (cap_err || cap_we) ? 32'd0 : load_data;
            end
            default: begin
                bus.req_ready = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit. A byte-level reference model and a word array stand in for data memory.
// Build with or without LSU_SUBWORD_EN, and the model follows the same macro.
module tb_load_store_unit;
`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_q[$];

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: asynchronous read and write on the edge that ends the strobe cycle.
    assign bus.mem_r_data = mem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (bus.mem_w_mem) mem[bus.mem_addr[7:2]] <= bus.mem_w_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model built from byte lanes.
    function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd2) return (addr % 4) != 0;
        if (SUBWORD && size == 2'd0) return 1'b0;
        if (SUBWORD && size == 2'd1) return (addr % 2) != 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                               input bit sgn, input logic [31:0] addr);
        int nb = 1 << size;
        int off = addr % 4;
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (((word >> (8 * (off + i))) & 32'hFF) << (8 * i));
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] size,
                                                input logic [31:0] addr, input logic [31:0] wdata);
        int nb = 1 << size;
        int off = addr % 4;
        for (int i = 0; i < nb; i++) begin
            word = (word & ~(32'hFF << (8 * (off + i)))) |
                   (((wdata >> (8 * i)) & 32'hFF) << (8 * (off + i)));
        end
        return word;
    endfunction

    // Driver: issue one request, scramble the bus while busy, then check the response and strobes.
    task automatic run_req(input bit we, input logic [1:0] size, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int          idx = addr[7:2];
        bit          e_err = model_err(size, addr);
        int          e_lat;
        logic [31:0] e_new;
        int          got_lat = 0;
        int          saw_r = 0;
        int          saw_w = 0;
        int          both = 0;
        logic [31:0] w_seen = 32'd0;
        logic [31:0] got_rdata = 32'hXXXX_XXXX;
        logic        got_err = 1'bx;
        e_lat = e_err ? 1 : (!we ? 2 : (size == 2'd2 ? 2 : 3));
        e_new = model_store(ref_mem[idx], size, addr, wdata);
        exp_q.push_back((e_err || we) ? 32'd0 : model_load(ref_mem[idx], size, sgn, addr));
        @(negedge clk);
        check("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
        bus.req_signed = sgn; bus.req_addr = addr; bus.req_wdata = wdata;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            bus.req_valid = 1'($urandom_range(0, 1)); bus.req_we = 1'($urandom_range(0, 1));
            bus.req_size = 2'($urandom_range(0, 3)); bus.req_signed = 1'($urandom_range(0, 1));
            bus.req_addr = $urandom; bus.req_wdata = $urandom;
            if (bus.mem_r_mem && bus.mem_w_mem) both++;
            if (bus.mem_r_mem || bus.mem_w_mem) check("mem_addr", bus.mem_addr, addr - (addr % 4));
            if (bus.mem_r_mem) saw_r++;
            if (bus.mem_w_mem) begin saw_w++; w_seen = bus.mem_w_data; end
            if (bus.resp_valid) begin
                got_lat = cyc; got_rdata = bus.resp_rdata; got_err = bus.resp_err;
                break;
            end
        end
        bus.req_valid = 1'b0;
        check("latency", got_lat, e_lat);
        check("resp_err", {31'd0, got_err}, {31'd0, e_err});
        check("resp_rdata", got_rdata, exp_q.pop_front());
        check("rd_strobes", saw_r, (!e_err && (!we || size != 2'd2)) ? 1 : 0);
        check("wr_strobes", saw_w, (!e_err && we) ? 1 : 0);
        check("strobe_overlap", both, 0);
        if (!e_err && we) begin
            check("mem_w_data", w_seen, e_new);
            ref_mem[idx] = e_new;
        end
    endtask

    initial begin
        int acc[$];
        int resp_seen;
        n_checks = 0; n_pass = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_strobes", {30'd0, bus.mem_r_mem, bus.mem_w_mem}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_w_data", bus.mem_w_data, 32'd0);

        // Fill memory through the unit with word stores.
        for (int i = 0; i < 64; i++) run_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);

        run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        check("deadbeef_mem", ref_mem[4], 32'hDEAD_BEEF);
        run_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344);
        run_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA);
        run_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h8000_FF80);
        run_req(1'b0, 2'd0, 1'b1, 32'h20, 32'd0);
        run_req(1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
        run_req(1'b0, 2'd2, 1'b0, 32'h13, 32'd0);
        run_req(1'b0, 2'd3, 1'b0, 32'h14, 32'd0);
        run_req(1'b0, 2'd1, 1'b1, 32'h15, 32'd0);

        for (int i = 0; i < 80; i++) begin
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 255)), $urandom);
        end

        // Reset during RD. Use a byte store when sub-word access is enabled, and a word load otherwise.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = SUBWORD; bus.req_size = SUBWORD ? 2'd0 : 2'd2;
        bus.req_signed = 1'b0; bus.req_addr = SUBWORD ? 32'h31 : 32'h30; bus.req_wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort_in_rd", {30'd0, bus.mem_r_mem, bus.mem_w_mem}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        resp_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.resp_valid || bus.mem_w_mem) resp_seen++;
            @(negedge clk);
        end
        check("abort_no_resp_or_write", resp_seen, 0);
        check("abort_mem_kept", mem[12], ref_mem[12]);

        // Reset takes priority over a simultaneous request.
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h0;
        @(negedge clk);
        rst = 1'b0; bus.req_valid = 1'b0;
        check("rst_priority_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_priority_no_rd", {31'd0, bus.mem_r_mem}, 32'd0);

        // Back-to-back word loads with req_valid held high.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h10;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (bus.req_ready) acc.push_back(cyc);
            if (bus.resp_valid) check("b2b_rdata", bus.resp_rdata, ref_mem[4]);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        check("b2b_count", acc.size(), 4);
        for (int i = 1; i < acc.size(); i++) check("b2b_spacing", acc[i] - acc[i - 1], 3);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
